// File: rtl/alu_cmd_sequencer.sv
// Command front end for the 16-bit ALU: issues one operation at a time, waits a fixed
// latency for the ALU result and returns it over a valid/ready response channel.
module alu_cmd_sequencer #(
    parameter int WIDTH = 16,
    parameter int OPW   = 4,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OPW-1:0]   cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_use_acc,
    input  logic             cmd_sub,
    output logic [OPW-1:0]   alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [WIDTH-1:0] alu_mode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_error,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_error,
    output logic [WIDTH-1:0] acc,
    output logic [7:0]       err_count
);

    localparam int CNT_W = (LAT < 2) ? 1 : $clog2(LAT + 1);

    localparam logic [OPW-1:0] OP_LAST_ALU = OPW'(11);
    localparam logic [OPW-1:0] OP_CLEAR    = OPW'(14);
    localparam logic [OPW-1:0] OP_NOOP     = OPW'(15);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             op_alu;
    logic             op_clear;
    logic             op_noop;
    logic             cmd_fire;
    logic             cnt_done;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign op_alu   = (cmd_op <= OP_LAST_ALU);
    assign op_clear = (cmd_op == OP_CLEAR);
    assign op_noop  = (cmd_op == OP_NOOP);
    assign cmd_fire = cmd_valid & cmd_ready;
    assign cnt_done = (cnt == CNT_W'(1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: CLEAR, NOOP and illegal opcodes skip the ALU wait
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cmd_fire) begin
                    state_nxt = op_alu ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (cnt_done) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        cmd_ready = (state == S_IDLE) & ~rst;
        rsp_valid = (state == S_RESP);
    end

    // Issue stage: ALU operand registers hold until the next ALU-bound command
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_mode   <= '0;
            cnt        <= '0;
        end else begin
            if (state == S_IDLE && cmd_valid && op_alu) begin
                alu_opcode <= cmd_op;
                alu_a      <= cmd_use_acc ? acc : cmd_a;
                alu_b      <= cmd_b;
                alu_mode   <= {WIDTH{cmd_sub}};
                cnt        <= CNT_W'(LAT);
            end else if (state == S_WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Response stage: local ops answer at once, ALU ops when the latency count expires
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_data  <= '0;
            rsp_error <= 1'b0;
            acc       <= '0;
            err_count <= '0;
        end else begin
            if (state == S_IDLE && cmd_valid && !op_alu) begin
                if (op_clear) begin
                    acc       <= '0;
                    rsp_data  <= '0;
                    rsp_error <= 1'b0;
                end else if (op_noop) begin
                    rsp_data  <= acc;
                    rsp_error <= 1'b0;
                end else begin
                    rsp_data  <= '0;
                    rsp_error <= 1'b1;
                    err_count <= sat_inc8(err_count);
                end
            end else if (state == S_WAIT && cnt_done) begin
                rsp_data  <= alu_result;
                rsp_error <= alu_error;
                if (alu_error) begin
                    err_count <= sat_inc8(err_count);
                end else begin
                    acc <= alu_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a registered ALU stand-in, a transaction-level reference
// model compared every cycle, and directed scenarios with literal expectations.
module tb_alu_cmd_sequencer;

    localparam int WIDTH = 16;
    localparam int OPW   = 4;
    localparam int LAT   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [OPW-1:0]   cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_use_acc;
    logic             cmd_sub;
    logic [OPW-1:0]   alu_opcode;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_mode;
    logic [WIDTH-1:0] alu_result;
    logic             alu_error;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_error;
    logic [WIDTH-1:0] acc;
    logic [7:0]       err_count;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.WIDTH(WIDTH), .OPW(OPW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .cmd_sub(cmd_sub),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
        .alu_result(alu_result), .alu_error(alu_error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_error(rsp_error), .acc(acc), .err_count(err_count)
    );

    // ALU behaviour: returns {error, result}
    function automatic logic [16:0] alu_fn(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [15:0] mode);
        logic [15:0] r;
        logic        e;
        r = 16'd0;
        e = 1'b0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = a ^ b;
            4'd3:  r = ~a;
            4'd4:  r = a << b[3:0];
            4'd5:  r = a >> b[3:0];
            4'd6:  r = a;
            4'd7:  r = b;
            4'd8:  r = {15'd0, a == b};
            4'd9:  r = a + (b ^ mode) + {15'd0, mode[0]};
            4'd10: r = a * b;
            4'd11: begin
                if (b == 16'd0) e = 1'b1;
                else r = a / b;
            end
            default: e = 1'b1;
        endcase
        return {e, r};
    endfunction

    logic [3:0]  r_op;
    logic [15:0] r_a, r_b, r_mode;
    always @(posedge clk) begin
        r_op   <= alu_opcode;
        r_a    <= alu_a;
        r_b    <= alu_b;
        r_mode <= alu_mode;
    end
    assign {alu_error, alu_result} = alu_fn(r_op, r_a, r_b, r_mode);

    int n_chk  = 0;
    int n_fail = 0;
    int n_sent = 0;
    int n_acc  = 0;
    int n_rsp  = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: one transaction at a time, response due LAT edges after issue
    bit          m_live = 1'b0;
    bit          m_idle, m_wait, m_rsp;
    int          m_due;
    logic [15:0] m_acc, m_rdata, p_res;
    logic        m_rerr, p_err;
    logic [7:0]  m_errc;
    logic [3:0]  m_op;
    logic [15:0] m_a, m_b, m_mode;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_live = 1'b1; m_idle = 1'b1; m_wait = 1'b0; m_rsp = 1'b0;
            m_acc = 16'd0; m_rdata = 16'd0; m_rerr = 1'b0; m_errc = 8'd0;
            m_op = 4'd0; m_a = 16'd0; m_b = 16'd0; m_mode = 16'd0;
        end else if (m_live) begin
            if (m_idle && cmd_valid) begin
                m_idle = 1'b0;
                if (cmd_op < 4'd12) begin
                    m_op   = cmd_op;
                    m_a    = cmd_use_acc ? m_acc : cmd_a;
                    m_b    = cmd_b;
                    m_mode = {16{cmd_sub}};
                    {p_err, p_res} = alu_fn(m_op, m_a, m_b, m_mode);
                    m_wait = 1'b1;
                    m_due  = cyc + LAT;
                end else begin
                    m_rsp = 1'b1;
                    if (cmd_op == 4'd14) begin
                        m_acc = 16'd0; m_rdata = 16'd0; m_rerr = 1'b0;
                    end else if (cmd_op == 4'd15) begin
                        m_rdata = m_acc; m_rerr = 1'b0;
                    end else begin
                        m_rdata = 16'd0; m_rerr = 1'b1;
                        if (m_errc != 8'd255) m_errc = m_errc + 8'd1;
                    end
                end
            end else if (m_wait && cyc == m_due) begin
                m_wait  = 1'b0;
                m_rsp   = 1'b1;
                m_rdata = p_res;
                m_rerr  = p_err;
                if (!p_err) m_acc = p_res;
                else if (m_errc != 8'd255) m_errc = m_errc + 8'd1;
            end else if (m_rsp && rsp_ready) begin
                m_rsp  = 1'b0;
                m_idle = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("cmd_ready", cmd_ready, m_idle && !rst);
            chk("rsp_valid", rsp_valid, m_rsp);
            chk("rsp_data", rsp_data, m_rdata);
            chk("rsp_error", rsp_error, m_rerr);
            chk("acc", acc, m_acc);
            chk("err_count", err_count, m_errc);
            chk("alu_opcode", alu_opcode, m_op);
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("alu_mode", alu_mode, m_mode);
            if (cmd_valid && cmd_ready) n_acc++;
            if (rsp_valid && rsp_ready) n_rsp++;
        end
    end

    task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic ua, input logic sub, output int t);
        int n;
        n = 0;
        t = 0;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_sub = sub;
        cmd_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin
                @(posedge clk);
                #1;
                t = cyc;
                break;
            end
            n++;
            if (n > 20) begin
                n_chk++; n_fail++;
                $display("FAIL cmd accept timeout: got no cmd_ready, expected within 20 cycles");
                @(posedge clk);
                #1;
                break;
            end
        end
        cmd_valid = 1'b0;
        n_sent++;
    endtask

    task automatic wait_rsp(input int t, output int lat, output logic [15:0] d, output logic e);
        int n;
        n = 0; lat = -1; d = 16'd0; e = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                lat = cyc - t + 1;
                d = rsp_data;
                e = rsp_error;
                break;
            end
            n++;
            if (n > 20) begin
                n_chk++; n_fail++;
                $display("FAIL rsp timeout: got no rsp_valid, expected within 20 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    int          t, lat, acc_before, rsp_before;
    logic [15:0] d;
    logic        e;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = 16'd0; cmd_b = 16'd0;
        cmd_use_acc = 1'b0; cmd_sub = 1'b0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset cmd_ready", cmd_ready, 0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset acc", acc, 0);
        chk("reset err_count", err_count, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready after reset", cmd_ready, 1);
        @(posedge clk); #1;

        // 1: add 3000 + 4000
        send(4'd9, 16'd3000, 16'd4000, 1'b0, 1'b0, t);
        @(negedge clk);
        chk("t1 alu_a", alu_a, 3000);
        chk("t1 alu_opcode", alu_opcode, 9);
        wait_rsp(t, lat, d, e);
        chk("t1 latency", lat, 3);
        chk("t1 rsp_data", d, 7000);
        chk("t1 rsp_error", e, 0);
        chk("t1 acc", acc, 7000);

        // 2: multiply accumulator by 3
        send(4'd10, 16'd0, 16'd3, 1'b1, 1'b0, t);
        @(negedge clk);
        chk("t2 alu_a", alu_a, 7000);
        wait_rsp(t, lat, d, e);
        chk("t2 rsp_data", d, 21000);
        chk("t2 acc", acc, 21000);

        // 3: divide by zero, then illegal opcode
        send(4'd11, 16'd100, 16'd0, 1'b0, 1'b0, t);
        wait_rsp(t, lat, d, e);
        chk("t3 div0 rsp_error", e, 1);
        chk("t3 div0 acc", acc, 21000);
        chk("t3 div0 err_count", err_count, 1);
        send(4'd12, 16'd55, 16'd66, 1'b0, 1'b0, t);
        wait_rsp(t, lat, d, e);
        chk("t3 illegal rsp_data", d, 0);
        chk("t3 illegal rsp_error", e, 1);
        chk("t3 illegal err_count", err_count, 2);

        // 4: CLEAR then NOOP
        send(4'd14, 16'd0, 16'd0, 1'b0, 1'b0, t);
        wait_rsp(t, lat, d, e);
        chk("t4 clear latency", lat, 1);
        chk("t4 clear rsp_data", d, 0);
        chk("t4 clear acc", acc, 0);
        chk("t4 clear alu_opcode", alu_opcode, 11);
        send(4'd15, 16'd0, 16'd0, 1'b0, 1'b0, t);
        wait_rsp(t, lat, d, e);
        chk("t4 noop rsp_data", d, 0);

        // 5: subtract 5 - 6 under response backpressure
        rsp_ready = 1'b0;
        send(4'd9, 16'd5, 16'd6, 1'b0, 1'b1, t);
        wait_rsp(t, lat, d, e);
        chk("t5 rsp_data", d, 16'hFFFF);
        chk("t5 latency", lat, 3);
        acc_before = n_acc;
        rsp_before = n_rsp;
        cmd_valid = 1'b1; cmd_op = 4'd9; cmd_a = 16'd1; cmd_b = 16'd1;
        cmd_use_acc = 1'b0; cmd_sub = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("t5 hold rsp_valid", rsp_valid, 1);
            chk("t5 hold rsp_data", rsp_data, 16'hFFFF);
            chk("t5 hold cmd_ready", cmd_ready, 0);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5 released rsp_valid", rsp_valid, 0);
        chk("t5 released cmd_ready", cmd_ready, 1);
        chk("t5 no extra accepts", n_acc - acc_before, 0);
        chk("t5 one rsp handshake", n_rsp - rsp_before, 1);
        chk("t5 acc", acc, 16'hFFFF);
        @(posedge clk); #1;
        send(4'd15, 16'd0, 16'd0, 1'b0, 1'b0, t);
        wait_rsp(t, lat, d, e);
        chk("t5 noop rsp_data", d, 16'hFFFF);

        // 6: reset during WAIT aborts the add
        send(4'd9, 16'd10, 16'd20, 1'b0, 1'b0, t);
        rst = 1'b1;
        @(negedge clk);
        chk("t6 cmd_ready in reset", cmd_ready, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("t6 cmd_ready after reset", cmd_ready, 1);
        chk("t6 rsp_valid", rsp_valid, 0);
        chk("t6 acc", acc, 0);
        chk("t6 err_count", err_count, 0);
        repeat (4) begin
            @(negedge clk);
            chk("t6 no response", rsp_valid, 0);
        end
        @(posedge clk); #1;
        send(4'd9, 16'd1, 16'd2, 1'b0, 1'b0, t);
        wait_rsp(t, lat, d, e);
        chk("t6 next rsp_data", d, 3);
        chk("t6 next latency", lat, 3);
        chk("t6 next acc", acc, 3);
        chk("t6 commands accepted", n_acc, n_sent);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 100000");
        $fatal(1, "watchdog");
    end

endmodule
